// File: rtl/fp_switch_bank.sv
// fp_switch_bank: N-channel front-panel switch conditioner.
// Each channel gets a synchroniser, a debounce qualifier and an optional
// one-shot with halt gating and auto-repeat. The trigger and collision
// outputs are derived combinationally from the registered pulse vector.
module fp_switch_bank #(
  parameter int                  CHANNELS        = 8,
  parameter int                  SYNC_STAGES     = 2,
  parameter int                  DEBOUNCE_CYCLES = 20,
  parameter logic [CHANNELS-1:0] PULSE_MASK      = 8'hFF,
  parameter logic [CHANNELS-1:0] REPEAT_MASK     = 8'h00,
  parameter int                  REPEAT_CYCLES   = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] sw,
  input  logic                enable,
  output logic [CHANNELS-1:0] level,
  output logic [CHANNELS-1:0] pulse,
  output logic                trigger,
  output logic                collision
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int RW = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;

  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] RP_LAST = RW'((REPEAT_CYCLES > 0) ? REPEAT_CYCLES - 1 : 0);
  // Repeat only makes sense on pulse channels, and only with a non-zero period.
  localparam logic [CHANNELS-1:0] RP_EN =
    (REPEAT_CYCLES > 0) ? (REPEAT_MASK & PULSE_MASK) : '0;

  logic [CHANNELS-1:0] sync_q [SYNC_STAGES];
  logic [CHANNELS-1:0] s;

  logic [DW-1:0]       db_cnt_q [CHANNELS];
  logic [DW-1:0]       db_cnt_d [CHANNELS];
  logic [RW-1:0]       rp_cnt_q [CHANNELS];
  logic [RW-1:0]       rp_cnt_d [CHANNELS];

  logic [CHANNELS-1:0] level_q, level_d;
  logic [CHANNELS-1:0] pulse_q, pulse_d;
  logic [CHANNELS-1:0] press;
  logic [CHANNELS-1:0] rp_hit;

  // Synchroniser chain: stage 0 samples the raw pins, last stage feeds debounce.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= '0;
      end
    end else begin
      sync_q[0] <= sw;
      for (int unsigned k = 1; k < SYNC_STAGES; k++) begin
        sync_q[k] <= sync_q[k-1];
      end
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  // Debounce: level follows s only after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_comb begin
    level_d = level_q;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      db_cnt_d[i] = '0;
      if (s[i] != level_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) begin
          level_d[i] = s[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + DW'(1);
        end
      end
    end
  end

  assign press = level_d & ~level_q;

  // Auto-repeat counters and one-shot generation; pulses are gated by enable
  // at the edge that would register them, so gated events are simply lost.
  always_comb begin
    rp_hit = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      rp_cnt_d[i] = '0;
      if (RP_EN[i] && level_d[i] && !press[i]) begin
        if (rp_cnt_q[i] == RP_LAST) begin
          rp_hit[i] = 1'b1;
        end else begin
          rp_cnt_d[i] = rp_cnt_q[i] + RW'(1);
        end
      end
    end
    pulse_d = PULSE_MASK & {CHANNELS{enable}} & (press | rp_hit);
  end

  // Channel state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      level_q <= '0;
      pulse_q <= '0;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        db_cnt_q[i] <= '0;
        rp_cnt_q[i] <= '0;
      end
    end else begin
      level_q <= level_d;
      pulse_q <= pulse_d;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        db_cnt_q[i] <= db_cnt_d[i];
        rp_cnt_q[i] <= rp_cnt_d[i];
      end
    end
  end

  assign level     = level_q;
  assign pulse     = pulse_q;
  assign trigger   = |pulse_q;
  // Two or more bits set <=> clearing the lowest set bit leaves something.
  assign collision = |(pulse_q & (pulse_q - CHANNELS'(1)));

endmodule

// File: tb/tb_fp_switch_bank.sv
// Directed bench for fp_switch_bank with the 4-channel test configuration.
module tb_fp_switch_bank;

  logic       clk;
  logic       reset;
  logic [3:0] sw;
  logic       enable;
  logic [3:0] level;
  logic [3:0] pulse;
  logic       trigger;
  logic       collision;

  int checks = 0;
  int errors = 0;

  fp_switch_bank #(
    .CHANNELS        (4),
    .SYNC_STAGES     (2),
    .DEBOUNCE_CYCLES (4),
    .PULSE_MASK      (4'b1011),
    .REPEAT_MASK     (4'b0010),
    .REPEAT_CYCLES   (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .sw        (sw),
    .enable    (enable),
    .level     (level),
    .pulse     (pulse),
    .trigger   (trigger),
    .collision (collision)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] sw;
    logic       en;
    logic [3:0] lvl;
    logic [3:0] pls;
    logic       trg;
    logic       col;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic [3:0] s, input logic [3:0] l, input logic [3:0] p,
                     input logic t, input logic c);
    vec_t v;
    v.sw = s; v.en = 1'b1; v.lvl = l; v.pls = p; v.trg = t; v.col = c;
    vecs.push_back(v);
  endtask

  // One clock: inputs already set at a negedge, sample at the next negedge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    sw = '0;
    for (int j = 0; j < n; j++) step();
  endtask

  initial begin
    int pcnt;
    int first;
    int fall;
    int pe[$];

    reset = 1'b0; sw = '0; enable = 1'b1;

    // Table: clean press ch0, release, then simultaneous ch0/ch2/ch3 press.
    add(4'b0000, 4'b0000, 4'b0000, 0, 0);                        // e0
    for (int j = 0; j < 5; j++) add(4'b0001, 4'b0000, 4'b0000, 0, 0); // e1..e5
    add(4'b0001, 4'b0001, 4'b0001, 1, 0);                        // e6
    add(4'b0001, 4'b0001, 4'b0000, 0, 0);                        // e7
    for (int j = 0; j < 5; j++) add(4'b0000, 4'b0001, 4'b0000, 0, 0); // e8..e12
    add(4'b0000, 4'b0000, 4'b0000, 0, 0);                        // e13
    for (int j = 0; j < 5; j++) add(4'b1101, 4'b0000, 4'b0000, 0, 0); // e14..e18
    add(4'b1101, 4'b1101, 4'b1001, 1, 1);                        // e19
    add(4'b1101, 4'b1101, 4'b0000, 0, 0);                        // e20
    for (int j = 0; j < 5; j++) add(4'b0000, 4'b1101, 4'b0000, 0, 0); // e21..e25
    add(4'b0000, 4'b0000, 4'b0000, 0, 0);                        // e26

    // Reset state.
    repeat (2) @(negedge clk);
    chk("reset_level", 32'(level), 32'(4'b0000));
    chk("reset_pulse", 32'(pulse), 32'(4'b0000));
    chk("reset_trig",  32'(trigger), 32'(1'b0));
    chk("reset_coll",  32'(collision), 32'(1'b0));
    reset = 1'b1;

    foreach (vecs[idx]) begin
      sw = vecs[idx].sw;
      enable = vecs[idx].en;
      step();
      chk($sformatf("vec%0d_level", idx), 32'(level), 32'(vecs[idx].lvl));
      chk($sformatf("vec%0d_pulse", idx), 32'(pulse), 32'(vecs[idx].pls));
      chk($sformatf("vec%0d_trig", idx), 32'(trigger), 32'(vecs[idx].trg));
      chk($sformatf("vec%0d_coll", idx), 32'(collision), 32'(vecs[idx].col));
    end
    idle(4);

    // Bounce on ch0: drive 1,0 then hold 1 from edge 2 -> level rises after edge 7.
    pcnt = 0; first = -1;
    for (int e = 0; e < 14; e++) begin
      sw = (e == 1) ? 4'b0000 : 4'b0001;
      step();
      if (pulse[0]) pcnt++;
      if (level[0] && first < 0) first = e;
    end
    chk("bounce_rise_edge", 32'(first), 32'(7));
    chk("bounce_pulse_cnt", 32'(pcnt), 32'(1));
    idle(10);

    // Gate on ch3: enable low at press edge, raised while held -> no pulse.
    pcnt = 0;
    for (int e = 0; e < 12; e++) begin
      sw = 4'b1000;
      enable = (e >= 6);
      step();
      if (pulse[3]) pcnt++;
    end
    chk("gate_level_held", 32'(level[3]), 32'(1'b1));
    chk("gate_no_pulse", 32'(pcnt), 32'(0));
    sw = '0;
    for (int e = 0; e < 8; e++) begin
      step();
      if (pulse[3]) pcnt++;
    end
    chk("gate_released", 32'(level[3]), 32'(1'b0));
    chk("gate_no_release_pulse", 32'(pcnt), 32'(0));
    for (int e = 0; e < 10; e++) begin
      sw = 4'b1000;
      step();
      if (pulse[3]) pcnt++;
    end
    chk("gate_repress_pulse", 32'(pcnt), 32'(1));
    idle(10);

    // Level channel ch2 never pulses.
    pcnt = 0;
    for (int e = 0; e < 10; e++) begin
      sw = 4'b0100;
      step();
      if (pulse != 4'b0000) pcnt++;
    end
    chk("lvl2_level", 32'(level[2]), 32'(1'b1));
    chk("lvl2_no_pulse", 32'(pcnt), 32'(0));
    idle(10);

    // Auto-repeat ch1: press edge 5, pulses after edges 5,13,21,29; sw released
    // before edge 31 so level falls after edge 36, ahead of the next wrap.
    fall = -1;
    pe.delete();
    for (int e = 0; e < 50; e++) begin
      sw = (e < 31) ? 4'b0010 : 4'b0000;
      step();
      if (pulse[1]) pe.push_back(e);
      if (!level[1] && e > 5 && fall < 0) fall = e;
    end
    chk("rpt_pulse_cnt", 32'(pe.size()), 32'(4));
    for (int j = 0; j < 4; j++) begin
      if (j < pe.size()) chk($sformatf("rpt_pulse%0d_edge", j), 32'(pe[j]), 32'(5 + 8 * j));
    end
    chk("rpt_release_edge", 32'(fall), 32'(36));
    idle(6);

    // Reset mid-pulse (ch3) and mid-debounce (ch0): outputs drop asynchronously.
    sw = 4'b1000;
    step(); step();
    sw = 4'b1001;
    step(); step(); step(); step();
    chk("rst_pre_pulse3", 32'(pulse), 32'(4'b1000));
    sw = 4'b0001;
    reset = 1'b0;
    #1;
    chk("rst_async_level", 32'(level), 32'(4'b0000));
    chk("rst_async_pulse", 32'(pulse), 32'(4'b0000));
    chk("rst_async_trig", 32'(trigger), 32'(1'b0));
    chk("rst_async_coll", 32'(collision), 32'(1'b0));
    repeat (3) @(negedge clk);
    reset = 1'b1;
    pcnt = 0; first = -1;
    for (int e = 0; e < 10; e++) begin
      step();
      if (pulse[0]) begin
        pcnt++;
        if (first < 0) first = e;
      end
    end
    chk("rst_held_pulse_edge", 32'(first), 32'(5));
    chk("rst_held_pulse_cnt", 32'(pcnt), 32'(1));
    idle(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp_switch_bank.md
# fp_switch_bank

Parametrised front-panel switch conditioner. It generalises the fixed PDP-8/E key debouncer to N channels, with per-channel pulse/level mode, halt-gated one-shots, optional auto-repeat and collision flagging. It sits between the raw panel switch pins and the front-panel/state-machine logic. Its outputs drive the `*d` strobes and `triggerd`.

## Interface
Parameters:
- CHANNELS, 8: number of switch channels.
- SYNC_STAGES, 2: synchroniser depth (≥2).
- DEBOUNCE_CYCLES, 20: consecutive clocks of agreement needed to change state (≥1).
- PULSE_MASK, 8'hFF: bit i=1 makes channel i a one-shot; bit i=0 makes it level-only.
- REPEAT_MASK, 8'h00: bit i=1 enables auto-repeat on channel i. Meaningful only where PULSE_MASK[i]=1.
- REPEAT_CYCLES, 0: repeat period in clocks; 0 disables all repeat.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  asynchronous, active-low reset.
- sw  input  CHANNELS  raw switch levels, asynchronous to clk, 1 = pressed.
- enable  input  1  pulse gate (driven high while the processor is halted).
- level  output  CHANNELS  debounced switch state.
- pulse  output  CHANNELS  one-clock strobes per channel.
- trigger  output  1  OR of all pulse bits, same cycle.
- collision  output  1  high for one clock when two or more pulse bits are set in that cycle.

## Operation
- Per channel:
  - sw[i] passes through SYNC_STAGES flops; s[i] is the last stage.
  - Each channel has a debounce counter, width $clog2(DEBOUNCE_CYCLES)+1.
- Debounce, on each edge:
  - s≠level and count<DEBOUNCE_CYCLES-1: count increments.
  - s≠level and count=DEBOUNCE_CYCLES-1: level<=s and count<=0.
  - s=level: count<=0. Any glitch restarts qualification.
- Press event: level[i] goes 0→1 on an edge.
  - If PULSE_MASK[i]=1 and enable=1 at that edge, pulse[i]=1 for exactly the following cycle.
  - If enable=0 at the press edge, the event is dropped, not deferred.
- Release produces no pulse. Level-mode channels never pulse; pulse[i] is tied 0.
- Auto-repeat, only if REPEAT_MASK[i]=1 and REPEAT_CYCLES>0:
  - A repeat counter clears on the press edge.
  - While level[i]=1 the counter increments each edge.
  - When it reaches REPEAT_CYCLES-1 it wraps to 0, and pulse[i] asserts the next cycle if enable=1.
  - Release clears the counter immediately.
  - enable=0 suppresses repeat pulses but the counter keeps running.
- Channels are fully independent; simultaneous pulses are all passed through.
  - trigger=|pulse.
  - collision=(popcount(pulse)≥2), combinational from the pulse registers.
- Reset (async assert) forces all of the following to 0: sync flops, level, counters, pulse, trigger, collision.
  - The first press after reset release needs full sync+debounce qualification.
  - A switch held through reset produces a press pulse after qualification.

## Timing
- sw change stable before edge k gives s changed after edge k+SYNC_STAGES-1.
- level changes after edge k+SYNC_STAGES-1+DEBOUNCE_CYCLES.
- pulse is high during the cycle following that edge, width exactly 1 clock.
- Repeat pulses occur every REPEAT_CYCLES clocks after the press pulse.
- trigger and collision are coincident with pulse; zero added latency.
- Outputs are registered except trigger/collision, which are derived only from registers.
- Reset deassertion mid-qualification: counting resumes from 0.
- Reset assertion mid-pulse: pulse drops asynchronously.

## Test plan
Parameters for all scenarios: CHANNELS=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, PULSE_MASK=4'b1011, REPEAT_MASK=4'b0010, REPEAT_CYCLES=8, enable=1 unless stated.
- Clean press: sw[0] 0→1 before edge 10 → level[0]=1 after edge 15; pulse[0]=trigger=1 for the single cycle after edge 15; collision=0.
- Bounce: sw[0] toggles 1,0,1 on alternating cycles, then holds 1 → no level change until 4 consecutive agreeing synced samples; exactly one pulse.
- Gate: enable=0 at the press edge of ch3 → level[3]=1, no pulse. Raise enable while held → still no pulse. Release and re-press with enable=1 → one pulse.
- Level channel and collision: ch2 press → level[2]=1, pulse[2] stays 0. ch0 and ch3 pressed simultaneously → pulse[0], pulse[3], trigger and collision all 1 in the same cycle.
- Auto-repeat: hold ch1 for 30 clocks after qualification → press pulse, then pulses every 8 clocks (3 repeats). Release → level[1]=0 after 5 edges, no further pulses.
- Reset: assert reset mid-debounce on ch0 → all outputs 0 immediately. Hold sw[0]=1 across reset release → pulse after 2+4 edges.
